// File: rtl/serial_receptor_if.sv
// rtl/serial_receptor_if.sv - line, consumer and status signals of the UART byte receiver
//
// Purpose : bundles every non-clock, non-reset signal of serial_receptor.
// Signals : RXD           asynchronous UART line, idle high
//           LEER          consumer acknowledge, one-cycle pulse
//           DATO[7:0]     last accepted byte
//           VALIDO        DATO holds an unread byte
//           SOBRECARGA    sticky overrun flag
//           ERROR_TRAMA   one-cycle pulse on a bad stop bit
//           ERROR_PARIDAD one-cycle pulse on a parity mismatch
//           OCUPADO       receiver is inside a frame
//           LEDS[7:0]     copy of DATO for the board display
// Modports: master = the receiver, slave = the line driver / byte consumer.

interface serial_receptor_if;
   logic       RXD;
   logic       LEER;
   logic [7:0] DATO;
   logic       VALIDO;
   logic       SOBRECARGA;
   logic       ERROR_TRAMA;
   logic       ERROR_PARIDAD;
   logic       OCUPADO;
   logic [7:0] LEDS;

   modport master (
      input  RXD,
      input  LEER,
      output DATO,
      output VALIDO,
      output SOBRECARGA,
      output ERROR_TRAMA,
      output ERROR_PARIDAD,
      output OCUPADO,
      output LEDS
   );

   modport slave (
      output RXD,
      output LEER,
      input  DATO,
      input  VALIDO,
      input  SOBRECARGA,
      input  ERROR_TRAMA,
      input  ERROR_PARIDAD,
      input  OCUPADO,
      input  LEDS
   );
endinterface

// File: rtl/serial_receptor.sv
// rtl/serial_receptor.sv - UART byte receiver, 8 data bits LSB first, 1 stop bit
//
// Purpose : oversampled UART receiver with a one-byte holding register,
//           overrun detection and framing-error reporting.
// Options : define PARIDAD_EN to expect an even-parity bit after bit 7.
//           Without it ERROR_PARIDAD is tied to 0; the port list is the same.
// Ports   : CLK50  system clock, all logic on its rising edge
//           RST    synchronous active-high reset
//           bus    serial_receptor_if.master (RXD, LEER in; DATO, VALIDO,
//                  SOBRECARGA, ERROR_TRAMA, ERROR_PARIDAD, OCUPADO, LEDS out)
// Param   : CLKS_PER_BIT  CLK50 cycles per bit (>= 2)

module serial_receptor #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic                CLK50,
   input  logic                RST,
   serial_receptor_if.master   bus
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   // The timer counts down and a sample is taken on the cycle it reads 0,
   // so "load N" is stored as N-1 and the range stays 0..CLKS_PER_BIT-1.
   localparam int HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
   localparam int FULL_M1 = CLKS_PER_BIT - 1;
   localparam logic [TW-1:0] T_HALF = HALF_M1[TW-1:0];
   localparam logic [TW-1:0] T_FULL = FULL_M1[TW-1:0];

   localparam logic [2:0] INICIO   = 3'd0;
   localparam logic [2:0] ARRANQUE = 3'd1;
   localparam logic [2:0] DATOS    = 3'd2;
`ifdef PARIDAD_EN
   localparam logic [2:0] PARIDAD  = 3'd3;
`endif
   localparam logic [2:0] PARADA   = 3'd4;
   localparam logic [2:0] ESPERA   = 3'd5;

   // Line synchronizer and edge history
   logic rx_meta_q, rx_meta_d;
   logic rx_sync_q, rx_sync_d;
   logic rx_prev_q, rx_prev_d;

   // Frame state
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          bad_q, bad_d;        // frame already known to be discarded

   // Consumer-visible registers
   logic [7:0] dato_q, dato_d;
   logic       valido_q, valido_d;
   logic       sobrecarga_q, sobrecarga_d;
   logic       err_trama_q, err_trama_d;
`ifdef PARIDAD_EN
   logic       err_par_q, err_par_d;
`endif

   logic accept;
   logic tick;
   logic rx;

   assign rx   = rx_sync_q;
   assign tick = (timer_q == '0);

   always_comb begin
      rx_meta_d    = bus.RXD;
      rx_sync_d    = rx_meta_q;
      rx_prev_d    = rx_sync_q;

      state_d      = state_q;
      timer_d      = timer_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      bad_d        = bad_q;
      err_trama_d  = 1'b0;
`ifdef PARIDAD_EN
      err_par_d    = 1'b0;
`endif
      accept       = 1'b0;

      case (state_q)
         INICIO: begin
            // A start bit is a 1 -> 0 transition of the synchronized line,
            // so a line stuck low after a break does not retrigger.
            if (rx_prev_q && !rx) begin
               state_d = ARRANQUE;
               timer_d = T_HALF;
            end
         end

         ARRANQUE: begin
            if (tick) begin
               if (!rx) begin
                  state_d = DATOS;
                  timer_d = T_FULL;
                  idx_d   = 3'd0;
                  bad_d   = 1'b0;
               end else begin
                  state_d = INICIO;   // glitch, not a real start bit
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         DATOS: begin
            if (tick) begin
               shift_d[idx_q] = rx;
               timer_d        = T_FULL;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef PARIDAD_EN
                  state_d = PARIDAD;
`else
                  state_d = PARADA;
`endif
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

`ifdef PARIDAD_EN
         PARIDAD: begin
            if (tick) begin
               // Even parity: data bits plus parity bit must XOR to 0.
               if ((^shift_q) ^ rx) begin
                  err_par_d = 1'b1;
                  bad_d     = 1'b1;
               end
               timer_d = T_FULL;
               state_d = PARADA;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
`endif

         PARADA: begin
            if (tick) begin
               if (rx) begin
                  accept  = !bad_q;
                  state_d = INICIO;
               end else begin
                  err_trama_d = 1'b1;
                  state_d     = ESPERA;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         ESPERA: begin
            // Hold off until the line returns to idle so a break
            // reports exactly one framing error.
            if (rx) begin
               state_d = INICIO;
            end
         end

         default: begin
            state_d = INICIO;
         end
      endcase
   end

   // Holding register, overrun and acknowledge handling
   always_comb begin
      dato_d       = dato_q;
      valido_d     = valido_q;
      sobrecarga_d = sobrecarga_q;

      if (accept) begin
         dato_d   = shift_q;
         valido_d = 1'b1;
         // A read in the same cycle consumes the old byte, so no overrun.
         if (valido_q && !bus.LEER) begin
            sobrecarga_d = 1'b1;
         end
      end else if (bus.LEER && valido_q) begin
         valido_d     = 1'b0;
         sobrecarga_d = 1'b0;
      end
   end

   always_ff @(posedge CLK50) begin
      if (RST) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= INICIO;
         timer_q      <= '0;
         idx_q        <= 3'd0;
         shift_q      <= 8'h00;
         bad_q        <= 1'b0;
         dato_q       <= 8'h00;
         valido_q     <= 1'b0;
         sobrecarga_q <= 1'b0;
         err_trama_q  <= 1'b0;
`ifdef PARIDAD_EN
         err_par_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q    <= rx_meta_d;
         rx_sync_q    <= rx_sync_d;
         rx_prev_q    <= rx_prev_d;
         state_q      <= state_d;
         timer_q      <= timer_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         bad_q        <= bad_d;
         dato_q       <= dato_d;
         valido_q     <= valido_d;
         sobrecarga_q <= sobrecarga_d;
         err_trama_q  <= err_trama_d;
`ifdef PARIDAD_EN
         err_par_q    <= err_par_d;
`endif
      end
   end

   assign bus.DATO        = dato_q;
   assign bus.LEDS        = dato_q;
   assign bus.VALIDO      = valido_q;
   assign bus.SOBRECARGA  = sobrecarga_q;
   assign bus.ERROR_TRAMA = err_trama_q;
   assign bus.OCUPADO     = (state_q != INICIO);
`ifdef PARIDAD_EN
   assign bus.ERROR_PARIDAD = err_par_q;
`else
   assign bus.ERROR_PARIDAD = 1'b0;
`endif

endmodule
